fp_add_sequencer: RTL and testbench
===================================

# fp_add_sequencer

Multi-cycle controller and datapath for IEEE-754 single-precision add/subtract. It runs the exponent-difference and fraction-alignment step iteratively, one bit per cycle, then sequences the add, normalize and pack steps. It sits between the operand source and the result consumer of the floating-point arithmetic unit, with valid/ready handshakes on both sides. It processes one operation at a time; rounding is truncation (round toward zero).

## Interface
- No parameters (fixed single precision: 1 sign, 8 exponent, 23 fraction bits).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operand pair and op are valid.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  32  operand A (IEEE-754 single).
- b  in  32  operand B (IEEE-754 single).
- sub  in  1  0: A+B, 1: A−B (B sign inverted at capture).
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- result  out  32  registered result; held stable while out_valid=1 and out_ready=0.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, UNPACK, ALIGN, ADD, NORM, PACK, DONE.
- IDLE: in_ready=1. On in_valid, capture a, b and sub, then go to UNPACK.
- UNPACK:
  - Build 24-bit mantissas with the hidden bit.
  - Exponent 0 means flush-to-zero (mantissa 0, denormals treated as zero).
  - Order operands so L has the larger exponent, or the larger mantissa on a tie. S is the other operand.
  - d = expL − expS.
  - If d ≥ 26: S mantissa = 0, d = 0.
  - Special cases go straight to DONE:
    - any NaN, or inf−inf: result 0x7FC00000.
    - otherwise any inf: signed inf.
    - both zero: +0, or −0 only if both are −0 after the sub inversion.
  - Non-special: go to ALIGN if d > 0, else ADD.
- ALIGN: each cycle shift S mantissa right by 1 (bits shifted out are discarded) and decrement d. Go to ADD when d reaches 1→0.
- ADD:
  - Compute a 25-bit sum if the effective signs are equal, otherwise mL − mS. The ordering guarantees the difference is non-negative.
  - Result sign = sign of L; exponent = expL.
- NORM, one cycle per step:
  - If mantissa = 0: result +0, go to PACK.
  - If bit24 = 1: shift right 1 and exp+1. Single step, then go to PACK.
  - Else if bit23 = 0: shift left 1 and exp−1 per cycle. If exp reaches 0, result is signed zero (flush) and go to PACK.
  - Else (bit23 = 1): go to PACK. This check cycle counts as one NORM cycle when no shift is needed.
- PACK:
  - If exp ≥ 255: signed inf (0x7F800000 / 0xFF800000).
  - Else result = {sign, exp[7:0], mant[22:0]}.
  - Go to DONE.
- DONE: out_valid=1, result stable. On out_ready, go to IDLE.

## Timing
- Reset values: state=IDLE, out_valid=0, result=0x00000000, busy=0. in_ready=1 from the first cycle after reset.
- rst asserted mid-operation aborts the operation at the next edge: the in-flight result is discarded and out_valid drops to 0.
- Latency for non-special operations, accept edge to first cycle with out_valid=1: 3 + A + N cycles.
  - A = alignment shifts (capped d, 0..25).
  - N = NORM cycles (≥1).
- Latency for special cases: 1 cycle (UNPACK → DONE).
- The next operation can be accepted in the cycle after out_valid && out_ready. No overlap between operations.
- in_valid while busy is ignored; the source must hold its data until in_ready.

## Test plan
- 1.5+2.5: a=0x3FC00000, b=0x40200000, sub=0 → result 0x40800000; A=1, N=1, out_valid 5 cycles after accept.
- 1.0−0.75: a=0x3F800000, b=0x3F400000, sub=1 → 0x3E800000; A=1, N=2, latency 6.
- Alignment cap and truncation:
  - a=0x3F800000, b=0x30800000 (d=30) → 0x3F800000, latency 4.
  - a=0x3F800000, b=0x33800000 (d=24) → 0x3F800000, latency 28.
- Specials:
  - 0x7F800000 − 0x7F800000 → 0x7FC00000, latency 1.
  - 0x3F800000 − 0x3F800000 → 0x00000000 via NORM zero path.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → result stable, in_ready=0, and a new in_valid is ignored. Release → IDLE next cycle, and the new operand is accepted.
- Reset mid-ALIGN: assert rst during a d=20 operation → next cycle out_valid=0, busy=0, in_ready=1. A following 1.5+2.5 returns 0x40800000.

Source files
------------

// File: rtl/fp_add_sequencer.sv
// rtl/fp_add_sequencer.sv - iterative IEEE-754 single-precision add/subtract sequencer
// Truncating adder: one alignment bit and one normalize step per cycle, one operation in flight.
module fp_add_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_PACK, S_DONE
  } state_t;

  state_t      state, state_nx;

  logic [31:0] a_q, b_q;
  logic        sign_l, sign_s;
  logic [9:0]  exp_q;
  logic [23:0] m_l, m_s;
  logic [24:0] mant_q;
  logic [4:0]  d_q;
  logic [31:0] result_q;

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic        a_nan, b_nan, a_inf, b_inf, a_is_l;
  logic [7:0]  el, es, d_raw;
  logic [23:0] ml_u, ms_u;
  logic        sl_u, ss_u;
  logic        cap;
  logic [4:0]  d_u;
  logic        special;
  logic [31:0] special_val;

  // b_q already carries the sub-inverted sign
  assign sa     = a_q[31];
  assign sb     = b_q[31];
  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign ma     = (ea == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
  assign mb     = (eb == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
  assign a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_is_l = (ea > eb) || ((ea == eb) && (ma >= mb));
  assign el     = a_is_l ? ea : eb;
  assign es     = a_is_l ? eb : ea;
  assign ml_u   = a_is_l ? ma : mb;
  assign ms_u   = a_is_l ? mb : ma;
  assign sl_u   = a_is_l ? sa : sb;
  assign ss_u   = a_is_l ? sb : sa;
  assign d_raw  = el - es;
  assign cap    = (d_raw >= 8'd26);
  assign d_u    = cap ? 5'd0 : d_raw[4:0];

  always_comb begin
    special     = 1'b1;
    special_val = 32'h0000_0000;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      special_val = 32'h7FC0_0000;
    end else if (a_inf) begin
      special_val = {sa, 8'hFF, 23'd0};
    end else if (b_inf) begin
      special_val = {sb, 8'hFF, 23'd0};
    end else if ((ea == 8'd0) && (eb == 8'd0)) begin
      special_val = {sa & sb, 31'd0};
    end else begin
      special = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:   if (in_valid) state_nx = S_UNPACK;
      S_UNPACK: begin
        if (special)          state_nx = S_DONE;
        else if (d_u != 5'd0) state_nx = S_ALIGN;
        else                  state_nx = S_ADD;
      end
      S_ALIGN:  if (d_q == 5'd1) state_nx = S_ADD;
      S_ADD:    state_nx = S_NORM;
      S_NORM: begin
        // a left shift that lands bit23 or underflows the exponent also ends the loop
        if ((mant_q == 25'd0) || mant_q[24] || mant_q[23]) state_nx = S_PACK;
        else if ((exp_q == 10'd1) || mant_q[22])           state_nx = S_PACK;
      end
      S_PACK:   state_nx = S_DONE;
      S_DONE:   if (out_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sign_l   <= 1'b0;
      sign_s   <= 1'b0;
      exp_q    <= 10'd0;
      m_l      <= 24'd0;
      m_s      <= 24'd0;
      mant_q   <= 25'd0;
      d_q      <= 5'd0;
      result_q <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= {b[31] ^ sub, b[30:0]};
          end
        end
        S_UNPACK: begin
          sign_l <= sl_u;
          sign_s <= ss_u;
          exp_q  <= {2'b00, el};
          m_l    <= ml_u;
          m_s    <= cap ? 24'd0 : ms_u;
          d_q    <= d_u;
          if (special) result_q <= special_val;
        end
        S_ALIGN: begin
          m_s <= m_s >> 1;
          d_q <= d_q - 5'd1;
        end
        S_ADD: begin
          mant_q <= (sign_l == sign_s) ? ({1'b0, m_l} + {1'b0, m_s})
                                       : ({1'b0, m_l} - {1'b0, m_s});
        end
        S_NORM: begin
          if (mant_q == 25'd0) begin
            sign_l <= 1'b0;
            exp_q  <= 10'd0;
          end else if (mant_q[24]) begin
            mant_q <= mant_q >> 1;
            exp_q  <= exp_q + 10'd1;
          end else if (!mant_q[23]) begin
            if (exp_q == 10'd1) begin
              mant_q <= 25'd0;
              exp_q  <= 10'd0;
            end else begin
              mant_q <= mant_q << 1;
              exp_q  <= exp_q - 10'd1;
            end
          end
        end
        S_PACK: begin
          result_q <= (exp_q >= 10'd255) ? {sign_l, 8'hFF, 23'd0}
                                         : {sign_l, exp_q[7:0], mant_q[22:0]};
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb/tb_fp_add_sequencer.sv - randomized self-checking bench for fp_add_sequencer
// Reference model computes result and latency from the arithmetic rules with plain integers.
module tb_fp_add_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fp_add_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic s,
                                output logic [31:0] r, output int lat);
    logic   sx, sy, sl, ss, xn, yn, xi, yi;
    int     ex, ey, el, es, d, e, n;
    longint mx, my, ml, ms, m;
    sx = x[31];
    sy = y[31] ^ s;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    lat = 1;
    if (xn || yn || (xi && yi && (sx != sy))) begin r = 32'h7FC00000; return; end
    if (xi) begin r = {sx, 8'hFF, 23'd0}; return; end
    if (yi) begin r = {sy, 8'hFF, 23'd0}; return; end
    if (ex == 0 && ey == 0) begin r = {sx & sy, 31'd0}; return; end
    mx = (ex == 0) ? 64'd0 : ((longint'(1) << 23) + longint'(x[22:0]));
    my = (ey == 0) ? 64'd0 : ((longint'(1) << 23) + longint'(y[22:0]));
    if (ex > ey || (ex == ey && mx >= my)) begin
      el = ex; ml = mx; sl = sx; es = ey; ms = my; ss = sy;
    end else begin
      el = ey; ml = my; sl = sy; es = ex; ms = mx; ss = sx;
    end
    d = el - es;
    if (d >= 26) begin ms = 0; d = 0; end
    ms = ms >> d;
    m = (sl == ss) ? ml + ms : ml - ms;
    e = el;
    n = 1;
    if (m == 0) begin
      r = 32'd0;
    end else begin
      if (m >= (longint'(1) << 24)) begin
        m = m / 2;
        e = e + 1;
      end else if (m < (longint'(1) << 23)) begin
        n = 0;
        while (m < (longint'(1) << 23) && e > 0) begin
          m = m * 2;
          e = e - 1;
          n = n + 1;
        end
        if (e == 0) m = 0;
      end
      if (e >= 255) r = {sl, 8'hFF, 23'd0};
      else          r = {sl, 8'(e), m[22:0]};
    end
    lat = 3 + d + n;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  initial begin : monitor
    logic [31:0] r;
    int          l;
    bit          rst_seen;
    bit          prev_hold;
    bit          prev_release;
    bit          pending;
    bit          seen;
    logic [31:0] prev_res;
    logic [31:0] exp_res;
    int          exp_lat;
    int          acc_cyc;
    rst_seen = 0; prev_hold = 0; prev_release = 0; pending = 0; seen = 0;
    prev_res = 0; exp_res = 0; exp_lat = 0; acc_cyc = 0;

    model(32'h3FC00000, 32'h40200000, 1'b0, r, l);
    chk("pin 1.5+2.5", r, 32'h40800000);       chk("pin lat 1.5+2.5", 32'(l), 32'd5);
    model(32'h3F800000, 32'h3F400000, 1'b1, r, l);
    chk("pin 1-0.75", r, 32'h3E800000);        chk("pin lat 1-0.75", 32'(l), 32'd6);
    model(32'h3F800000, 32'h30800000, 1'b0, r, l);
    chk("pin cap d30", r, 32'h3F800000);       chk("pin lat d30", 32'(l), 32'd4);
    model(32'h3F800000, 32'h33800000, 1'b0, r, l);
    chk("pin trunc d24", r, 32'h3F800000);     chk("pin lat d24", 32'(l), 32'd28);
    model(32'h7F800000, 32'h7F800000, 1'b1, r, l);
    chk("pin inf-inf", r, 32'h7FC00000);       chk("pin lat inf-inf", 32'(l), 32'd1);
    model(32'h3F800000, 32'h3F800000, 1'b1, r, l);
    chk("pin 1-1", r, 32'h00000000);
    model(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, r, l);
    chk("pin overflow", r, 32'h7F800000);
    model(32'h00C00000, 32'h00800000, 1'b1, r, l);
    chk("pin underflow flush", r, 32'h00000000);

    forever begin
      @(negedge clk);
      if (rst) begin
        rst_seen = 1; pending = 0; prev_hold = 0; prev_release = 0;
      end else begin
        if (rst_seen) begin
          chk("reset out_valid", 32'(out_valid), 32'd0);
          chk("reset busy", 32'(busy), 32'd0);
          chk("reset in_ready", 32'(in_ready), 32'd1);
          chk("reset result", result, 32'd0);
          rst_seen = 0;
        end
        chk("in_ready vs busy", 32'(in_ready), 32'(!busy));
        if (prev_release) chk("idle after release", 32'(in_ready), 32'd1);
        if (out_valid && prev_hold) chk("result held", result, prev_res);
        if (in_valid && in_ready) begin
          model(a, b, sub, exp_res, exp_lat);
          acc_cyc = cyc + 1;
          pending = 1;
          seen = 0;
        end
        if (out_valid) begin
          if (!pending) begin
            checks++; errors++;
            $display("FAIL unexpected out_valid: result %08h with no accepted op (cycle %0d)", result, cyc);
          end else begin
            if (!seen) begin
              chk("latency", 32'(cyc - acc_cyc), 32'(exp_lat));
              seen = 1;
            end
            chk("result", result, exp_res);
            if (out_ready) pending = 0;
          end
        end else if (pending && (cyc - acc_cyc > 80)) begin
          checks++; errors++;
          $display("FAIL timeout: no out_valid %0d cycles after accept, expected %08h", cyc - acc_cyc, exp_res);
          pending = 0;
        end
        prev_hold    = out_valid && !out_ready;
        prev_release = out_valid && out_ready;
        prev_res     = result;
      end
    end
  end

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
  endtask

  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic s, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    a = x; b = y; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom);
    wait_valid();
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_fp(input int base);
    int          k, e;
    logic [22:0] f;
    logic        sg;
    k  = int'($urandom_range(0, 19));
    f  = 23'($urandom);
    sg = 1'($urandom);
    if (k == 0) return {sg, 8'h00, f};
    if (k == 1) return {sg, 8'hFF, 23'd0};
    if (k == 2) return {sg, 8'hFF, f | 23'd1};
    e = base + int'($urandom_range(0, 30)) - 15;
    if (e < 1)   e = 1;
    if (e > 254) e = 254;
    return {sg, 8'(e), f};
  endfunction

  initial begin : driver
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    do_op(32'h3FC00000, 32'h40200000, 1'b0, 0);
    do_op(32'h3F800000, 32'h3F400000, 1'b1, 1);
    do_op(32'h3F800000, 32'h30800000, 1'b0, 0);
    do_op(32'h3F800000, 32'h33800000, 1'b0, 2);
    do_op(32'h7F800000, 32'h7F800000, 1'b1, 0);
    do_op(32'h3F800000, 32'h3F800000, 1'b1, 0);
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 0);
    do_op(32'h00C00000, 32'h00800000, 1'b1, 0);
    do_op(32'h80000000, 32'h00000000, 1'b1, 0);

    // backpressure: DONE held 10 cycles while a new operand waits
    a = 32'h3F800000; b = 32'h40000000; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid();
    a = 32'h40400000; b = 32'h3F800000; sub = 1'b1; in_valid = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // reset while aligning a d=20 operation
    a = 32'h3F800000; b = 32'h35800000; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(32'h3FC00000, 32'h40200000, 1'b0, 0);

    for (int i = 0; i < 150; i++) begin
      int          base;
      logic [31:0] x, y;
      base = int'($urandom_range(1, 254));
      x = rand_fp(base);
      y = ($urandom_range(0, 5) == 0) ? (x ^ 32'($urandom_range(0, 255))) : rand_fp(base);
      do_op(x, y, 1'($urandom), int'($urandom_range(0, 2)));
    end

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
